ps2_host_tx: RTL

PS/2 host-to-device transmitter. Sends single command bytes to the keyboard, such as LED set 0xED, enable 0xF4 and reset 0xFF, over the same PS2Clk/PS2Data lines that the PS/2 receiver path listens on. It drives the lines open-drain through active-high pull-low enables, handles the inhibit/request-to-send sequence, shifts out the frame on device-generated clocks, and checks the device ACK bit. While it is busy, the receiver path must ignore the lines (`rx_inhibit`).

---
 rtl/ps2_pkg.sv | 31 +++
 rtl/ps2_host_tx_if.sv | 20 ++
 rtl/ps2_sync_edge.sv | 46 ++++
 rtl/ps2_host_tx.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// +--------------------------------------------------------------------------+
// | ps2_pkg : shared PS/2 host transmitter types and command constants       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_INHIBIT    = 3'd1,
    ST_REQ        = 3'd2,
    ST_WAIT_FIRST = 3'd3,
    ST_SEND       = 3'd4,
    ST_ACK        = 3'd5,
    ST_WAIT_IDLE  = 3'd6
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;
  localparam logic [7:0] PS2_RSP_BAT_OK  = 8'hAA;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
// +--------------------------------------------------------------------------+
// | ps2_host_tx_if : command byte handshake and completion pulses            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       done;
  logic       err;

  modport master (output tx_data, output tx_valid,
                  input  tx_ready, input done, input err);
  modport slave  (input  tx_data, input tx_valid,
                  output tx_ready, output done, output err);
endinterface

`default_nettype wire

// File: rtl/ps2_sync_edge.sv
// +--------------------------------------------------------------------------+
// | ps2_sync_edge : 2-FF pin synchronizers plus registered PS2Clk fall strobe|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic r_clk_meta, r_clk_sync, r_clk_prev;
  logic r_dat_meta, r_dat_sync;
  logic r_fall;

  // Idle bus level is high, so reset to 1 to avoid a spurious fall strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
      r_fall     <= 1'b0;
    end else begin
      r_clk_meta <= clk_in;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
      r_dat_meta <= data_in;
      r_dat_sync <= r_dat_meta;
      r_fall     <= r_clk_prev & ~r_clk_sync;
    end
  end

  assign clk_sync  = r_clk_sync;
  assign data_sync = r_dat_sync;
  assign clk_fall  = r_fall;

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// +--------------------------------------------------------------------------+
// | ps2_host_tx : PS/2 host-to-device command transmitter (open-drain)       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES       = 10_000,
  parameter int START_TIMEOUT_CYCLES = 1_500_000,
  parameter int FRAME_TIMEOUT_CYCLES = 200_000
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe,
  output logic         rx_inhibit
);

  localparam int c_MAX_A   = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ?
                             INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
  localparam int c_MAX_CNT = (c_MAX_A > FRAME_TIMEOUT_CYCLES) ? c_MAX_A : FRAME_TIMEOUT_CYCLES;
  localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);

  localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_INH_LAST   = c_CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_START_LAST = c_CNT_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_FRAME_LAST = c_CNT_W'(FRAME_TIMEOUT_CYCLES - 1);

  ps2_tx_state_e      r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]         r_bitcnt, w_bitcnt_nxt;
  logic [9:0]         r_shift, w_shift_nxt;
  logic               r_dat_oe, w_dat_oe_nxt;
  logic               r_done, w_done_nxt;
  logic               r_err, w_err_nxt;

  logic w_clk_s, w_dat_s, w_fall, w_frame_to;

  ps2_sync_edge u_sync (
    .clk       (clk),
    .rst       (rst),
    .clk_in    (ps2_clk_in),
    .data_in   (ps2_data_in),
    .clk_sync  (w_clk_s),
    .data_sync (w_dat_s),
    .clk_fall  (w_fall)
  );

  assign w_frame_to = (r_cnt == c_FRAME_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_dat_oe <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_dat_oe <= w_dat_oe_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_dat_oe_nxt = r_dat_oe;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_dat_oe_nxt = 1'b0;
        if (tx.tx_valid) begin
          // Frame bits in shift order: data LSB-first, parity, stop.
          w_shift_nxt = {1'b1, odd_parity(tx.tx_data), tx.tx_data};
          w_cnt_nxt   = '0;
          w_state_nxt = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (r_cnt == c_INH_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_REQ;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      ST_REQ: begin
        w_cnt_nxt    = '0;
        w_bitcnt_nxt = '0;
        w_dat_oe_nxt = 1'b1;
        w_state_nxt  = ST_WAIT_FIRST;
      end
      ST_WAIT_FIRST: begin
        if (w_fall) begin
          w_cnt_nxt    = '0;
          w_bitcnt_nxt = 4'd1;
          w_dat_oe_nxt = ~r_shift[0];
          w_shift_nxt  = {1'b1, r_shift[9:1]};
          w_state_nxt  = ST_SEND;
        end else if (r_cnt == c_START_LAST) begin
          w_err_nxt    = 1'b1;
          w_dat_oe_nxt = 1'b0;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
        w_cnt_nxt = r_cnt + c_CNT_ONE;
        if (w_frame_to) begin
          w_err_nxt    = 1'b1;
          w_dat_oe_nxt = 1'b0;
          w_state_nxt  = ST_IDLE;
        end else if (r_state == ST_WAIT_IDLE) begin
          if (w_clk_s && w_dat_s) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else if (w_fall) begin
          if (r_state == ST_SEND) begin
            // Edge 10 puts out the stop bit (a 1), which releases data.
            w_bitcnt_nxt = r_bitcnt + 4'd1;
            w_dat_oe_nxt = ~r_shift[0];
            w_shift_nxt  = {1'b1, r_shift[9:1]};
            if (r_bitcnt == 4'd9) begin
              w_state_nxt = ST_ACK;
            end
          end else begin
            w_bitcnt_nxt = 4'd11;
            if (!w_dat_s) begin
              w_state_nxt = ST_WAIT_IDLE;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end
        end
      end
      default: begin
        w_dat_oe_nxt = 1'b0;
        w_state_nxt  = ST_IDLE;
      end
    endcase
  end

  assign tx.tx_ready  = (r_state == ST_IDLE) && !rst;
  assign tx.done      = r_done && !rst;
  assign tx.err       = r_err && !rst;
  assign ps2_clk_oe   = ((r_state == ST_INHIBIT) || (r_state == ST_REQ)) && !rst;
  assign ps2_data_oe  = ((r_state == ST_REQ) || r_dat_oe) && !rst;
  assign rx_inhibit   = (r_state != ST_IDLE) && !rst;

endmodule

`default_nettype wire
